// File: rtl/pri_arb_pkg.sv
// Shared constants, state encoding and width helper for the priority / round-robin arbiter.
package pri_arb_pkg;

  localparam int PRI_FIXED = 0;
  localparam int PRI_RR    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pri_pick_n.sv
// Combinational picker: first set request bit scanning downward from ptr, wrapping 0 -> N-1.
module pri_pick_n
  import pri_arb_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx
);

  logic         found;
  logic [W-1:0] pos;
  int           p;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    p      = 0;
    for (int i = 0; i < N; i++) begin
      p = int'(ptr) - i;
      if (p < 0) p = p + N;
      pos = W'(p);
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/pri_arb_rr.sv
// N-way arbiter with fixed or round-robin priority and an optional grant tenure limit.
//   state   | meaning
//   ST_IDLE | no owner, gnt == 0, idle == 1
//   ST_BUSY | owner held in gnt/gnt_id, hold_q counts its cycles
module pri_arb_rr
  import pri_arb_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int RR       = PRI_RR,
  parameter  int MAX_HOLD = 0,
  localparam int W        = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         idle
);

  localparam int             HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [W-1:0]   PTR_TOP   = W'(N - 1);

  arb_state_t    state_q, state_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  gnt_d;
  logic [W-1:0]  gnt_id_d;
  logic          idle_d;

  logic [N-1:0]  pick_req;
  logic [N-1:0]  pick_onehot;
  logic [W-1:0]  pick_idx;
  logic          owner_req;
  logic          others;
  logic          hold_hit;
  logic          do_grant;

  // Owner is masked out of the candidate set; in IDLE gnt is zero so this is plain req.
  assign pick_req  = req & ~gnt;
  assign owner_req = |(req & gnt);
  assign others    = |pick_req;
  assign hold_hit  = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);

  pri_pick_n #(.N(N)) u_pick (
    .req    (pick_req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    idle_d   = idle;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    do_grant = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (others) do_grant = 1'b1;
      end
      ST_BUSY: begin
        if (owner_req && !(hold_hit && others)) begin
          // Limit reached with nobody waiting: keep the owner and restart its tenure.
          hold_d = ((MAX_HOLD == 0) || hold_hit) ? '0 : hold_q + HW'(1);
        end else if (others) begin
          do_grant = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
          idle_d   = 1'b1;
          hold_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_grant) begin
      state_d  = ST_BUSY;
      gnt_d    = pick_onehot;
      gnt_id_d = pick_idx;
      idle_d   = 1'b0;
      hold_d   = '0;
      if (RR == PRI_RR) ptr_d = (pick_idx == '0) ? PTR_TOP : pick_idx - W'(1);
      else              ptr_d = PTR_TOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      idle    <= 1'b1;
      ptr_q   <= PTR_TOP;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      idle    <= idle_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_pri_arb_rr.sv
// Directed and randomized checks of pri_arb_rr in fixed, round-robin and hold-limited configurations.
module tb_pri_arb_rr;

  logic       clk = 1'b0;
  logic       rst_f, rst_r, rst_h;
  logic [7:0] req_f, req_r, req_h;
  logic [7:0] gnt_f, gnt_r, gnt_h;
  logic [2:0] id_f, id_r, id_h;
  logic       idle_f, idle_r, idle_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pri_arb_rr #(.N(8), .RR(0), .MAX_HOLD(0)) u_fix (
    .clk(clk), .rst(rst_f), .req(req_f), .gnt(gnt_f), .gnt_id(id_f), .idle(idle_f));

  pri_arb_rr #(.N(8), .RR(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rst(rst_r), .req(req_r), .gnt(gnt_r), .gnt_id(id_r), .idle(idle_r));

  pri_arb_rr #(.N(8), .RR(1), .MAX_HOLD(4)) u_hold (
    .clk(clk), .rst(rst_h), .req(req_h), .gnt(gnt_h), .gnt_id(id_h), .idle(idle_h));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] r;
    logic [2:0] exp_id;
    int         e;
    int         wait_cnt [8];
    int         max_wait;

    rst_f = 1'b1; rst_r = 1'b1; rst_h = 1'b1;
    req_f = '0;   req_r = '0;   req_h = '0;
    tick();
    tick();
    chk("rst_gnt",  32'(gnt_f),  32'h0);
    chk("rst_id",   32'(id_f),   32'h0);
    chk("rst_idle", 32'(idle_f), 32'h1);
    rst_f = 1'b0; rst_r = 1'b0; rst_h = 1'b0;

    // Fixed priority
    tick();
    chk("fix_idle_stay", 32'(idle_f), 32'h1);
    req_f = 8'h81;
    tick();
    chk("fix_gnt80",  32'(gnt_f),  32'h80);
    chk("fix_id7",    32'(id_f),   32'h7);
    chk("fix_busy",   32'(idle_f), 32'h0);
    req_f = 8'h01;
    tick();
    chk("fix_gnt01",  32'(gnt_f),  32'h01);
    chk("fix_id0",    32'(id_f),   32'h0);
    req_f = 8'h81;
    tick();
    chk("fix_hold01", 32'(gnt_f),  32'h01);
    req_f = 8'h00;
    tick();
    chk("fix_to_idle_gnt", 32'(gnt_f),  32'h0);
    chk("fix_to_idle",     32'(idle_f), 32'h1);
    req_f = 8'h24;
    tick();
    chk("fix_gnt20",  32'(gnt_f),  32'h20);
    chk("fix_id5",    32'(id_f),   32'h5);
    req_f = 8'h04;
    tick();
    chk("fix_gnt04",  32'(gnt_f),  32'h04);
    chk("fix_id2",    32'(id_f),   32'h2);

    // Round-robin rotation 7,6,...,0,7 with no idle cycle
    req_r = 8'hFF;
    e = 7;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rr_id_%0d", i),   32'(id_r),   32'(e));
      chk($sformatf("rr_gnt_%0d", i),  32'(gnt_r),  32'(1) << e);
      chk($sformatf("rr_idle_%0d", i), 32'(idle_r), 32'h0);
      req_r = 8'hFF & ~(8'h01 << e);
      e = (e + 7) % 8;
    end

    // Hold limit with a competitor: owner 3 for 4 cycles, then 2, then back to 3
    req_h = 8'h0C;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("hold3_%0d", i), 32'(gnt_h), 32'h08);
    end
    tick();
    chk("hold_sw2", 32'(gnt_h), 32'h04);
    for (int i = 6; i <= 8; i++) begin
      tick();
      chk($sformatf("hold2_%0d", i), 32'(gnt_h), 32'h04);
    end
    tick();
    chk("hold_sw3", 32'(gnt_h), 32'h08);

    // Requester 3 alone keeps the grant past the limit
    req_h = 8'h08;
    for (int i = 10; i <= 19; i++) begin
      tick();
      chk($sformatf("alone3_%0d", i), 32'(gnt_h), 32'h08);
    end
    req_h = 8'h0C;
    tick();
    chk("restart_hold3", 32'(gnt_h), 32'h08);
    tick();
    chk("restart_sw2",   32'(gnt_h), 32'h04);

    // Reset mid-tenure while owner 5 holds
    req_h = 8'h20;
    tick();
    chk("pre_rst_gnt20", 32'(gnt_h), 32'h20);
    rst_h = 1'b1;
    tick();
    chk("mid_rst_gnt",  32'(gnt_h),  32'h0);
    chk("mid_rst_idle", 32'(idle_h), 32'h1);
    chk("mid_rst_id",   32'(id_h),   32'h0);
    rst_h = 1'b0;
    req_h = 8'h21;
    tick();
    chk("post_rst_gnt20", 32'(gnt_h), 32'h20);
    chk("post_rst_id5",   32'(id_h),  32'h5);

    // Random requests: invariants and bounded waiting
    for (int k = 0; k < 8; k++) wait_cnt[k] = 0;
    max_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      r = 8'(~($urandom & $urandom & $urandom));
      req_h = r;
      prev  = r;
      tick();
      exp_id = '0;
      for (int k = 0; k < 8; k++) if (gnt_h[k]) exp_id = 3'(k);
      chk("rnd_onehot",  32'(gnt_h & (gnt_h - 8'h01)), 32'h0);
      chk("rnd_idle",    32'(idle_h), 32'(gnt_h == 8'h00));
      chk("rnd_id",      32'(id_h),   32'(exp_id));
      chk("rnd_noreq",   32'(gnt_h & ~prev), 32'h0);
      chk("rnd_nobubble", 32'(gnt_h != 8'h00), 32'(prev != 8'h00));
      for (int k = 0; k < 8; k++) begin
        if (prev[k] && !gnt_h[k]) wait_cnt[k]++;
        else                      wait_cnt[k] = 0;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
    end
    chk("rnd_max_wait_le_32", 32'(max_wait <= 32), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pri_arb_rr.md
PRI_ARB_RR -- requirements
Module: pri_arb_rr

Interface
REQ-001 Parameter N, default 8: number of requesters; legal range 2..32.
REQ-002 Parameter RR, default 1: 0 = fixed priority, 1 = round-robin.
REQ-003 Parameter MAX_HOLD, default 0: maximum grant tenure in cycles; 0 = unlimited.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port req, input, N bits: request vector; bit k high = requester k wants access.
REQ-008 Port gnt, output, N bits: registered one-hot grant.
REQ-009 Port gnt_id, output, max(1,clog2(N)) bits: binary index of the granted requester; 0 when no grant.
REQ-010 Port idle, output, 1 bit: registered; high when no grant is held.

Function
REQ-011 The block SHALL have two states: IDLE (no owner) and BUSY (owner held in gnt).
REQ-012 Arbitration: among the eligible req bits, the block SHALL pick the first one in descending index order, starting from the top pointer and wrapping from 0 to N-1.
REQ-013 Fixed mode (RR=0): the top pointer is always N-1, so the highest index wins.
REQ-014 RR mode (RR=1): after granting index k, the top pointer becomes (k-1) mod N; the pointer changes only when a new grant is issued.
REQ-015 Latency: a grant SHALL appear on gnt, gnt_id and idle exactly one cycle after the req edge on which the block arbitrates.
REQ-016 IDLE with req==0: stay in IDLE; gnt=0, gnt_id=0, idle=1.
REQ-017 IDLE with req!=0: arbitrate, register the winner, go to BUSY.
REQ-018 BUSY with req[owner]=1 and the hold limit not reached: the grant SHALL be held unchanged, even if higher-priority requests arrive.
REQ-019 BUSY with req[owner]=0: re-arbitrate on the same cycle over the current req with no bubble cycle; if req==0, go to IDLE.
REQ-020 Hold counter: counts owner cycles; it SHALL clear to 0 on every new grant.
REQ-021 Hold limit (MAX_HOLD>0): when the counter reaches MAX_HOLD-1 and another req bit is high, the owner SHALL be excluded and the next edge SHALL grant another requester.
REQ-022 Hold limit with no other requester: the owner keeps the grant and the counter restarts at 0.
REQ-023 gnt SHALL always be zero or one-hot, and gnt[gnt_id] SHALL equal ~idle.
REQ-024 Output gnt SHALL never assert for a requester whose req was low on the arbitration cycle.

Reset
REQ-025 While rst is high at a clk edge, the next-state values SHALL be: state=IDLE, gnt=0, gnt_id=0, idle=1, top pointer=N-1, hold counter=0.
REQ-026 Reset mid-tenure SHALL drop the grant on the same edge; arbitration resumes on the first edge with rst low.

Structure
REQ-027 Package pri_arb_pkg SHALL hold the mode constants (PRI_FIXED=0, PRI_RR=1) and the index-width function.
REQ-028 Sub-module pri_pick_n (combinational, parameter N) SHALL return the one-hot and index of the highest set bit of the request vector after rotation by the pointer; pri_arb_rr owns all registers.
REQ-029 The expected implementation size is 120-400 lines of RTL in total.

Verification
REQ-030 Fixed-priority scenario (N=8, RR=0): req=8'h81 -> one cycle later gnt=8'h80, gnt_id=7, idle=0; drop req[7] -> next edge gnt=8'h01, gnt_id=0.
REQ-031 Round-robin scenario (N=8, RR=1, req=8'hFF held): each requester drops its req for one cycle after being granted -> grants rotate 7,6,5,...,0,7 with no idle cycle.
REQ-032 Hold-limit scenario (MAX_HOLD=4): req=8'h0C, owner 3 holds -> after 4 cycles, gnt=8'h04.
REQ-033 Hold-limit scenario, requester 3 alone: owner 3 holds past the limit -> gnt stays 8'h08.
REQ-034 Reset scenario: rst pulsed for one cycle while gnt=8'h20 -> next edge gnt=0, idle=1, pointer=7; with req=8'h21 after reset -> gnt=8'h20.
REQ-035 Random req for 10k cycles -> the one-hot, REQ-023 and REQ-024 assertions hold, and no requester waits more than N*MAX_HOLD cycles in RR mode.
